ad7606_avg: RTL and testbench



---
 rtl/ad7606_pkg.sv | 18 +
 rtl/ad7606_avg_acc.sv | 49 ++++
 rtl/ad7606_avg.sv | 200 ++++++++++++++++++++
 tb/tb_ad7606_avg.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ad7606_pkg.sv
// ad7606_pkg
// Shared constants and types for the AD7606 averaging path.
//   CH_NUM      : words per conversion frame (channel 0 first)
//   DW          : sample width, two's complement
//   CH_W        : width of a channel index
//   out_state_t : output stream state (IDLE, SEND)
package ad7606_pkg;

  localparam int CH_NUM = 8;
  localparam int DW     = 16;
  localparam int CH_W   = 3;

  typedef enum logic {
    IDLE,
    SEND
  } out_state_t;

endpackage

// File: rtl/ad7606_avg_acc.sv
// ad7606_avg_acc
// One channel's accumulate / shift / clear slice.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   en       : a word for this channel is accepted this cycle
//   clr      : discard the running sum (framing restart)
//   fin      : this word belongs to the final frame of the block
//   data     : signed input sample
//   avg      : (running sum + data) >>> AVG_LOG2, valid whenever en is high
module ad7606_avg_acc
  import ad7606_pkg::*;
#(
  parameter int AVG_LOG2 = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 clr,
  input  logic                 fin,
  input  logic signed [DW-1:0] data,
  output logic signed [DW-1:0] avg
);

  // 2^AVG_LOG2 samples of DW bits can never overflow this width.
  localparam int AW = DW + AVG_LOG2;

  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] base;
  logic signed [AW-1:0] sum;

  // A clear on the same cycle as a word means the word starts a fresh sum.
  always_comb begin
    base = clr ? '0 : acc;
    sum  = base + AW'(data);
    avg  = DW'(sum >>> AVG_LOG2);
  end

  // After the final frame the sum is handed to the buffer and restarts at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (en) begin
      acc <= fin ? '0 : sum;
    end else if (clr) begin
      acc <= '0;
    end
  end

endmodule

// File: rtl/ad7606_avg.sv
// ad7606_avg
// Per-channel block averager behind the AD7606 capture block. Accumulates
// 2^AVG_LOG2 conversion frames per channel, then streams one averaged word
// per channel over valid/ready.
// Ports:
//   clk, rst   : 50 MHz clock, synchronous active-high reset
//   in_valid   : sample word strobe
//   in_sof     : marks the channel-0 word of a frame
//   in_data    : signed sample
//   out_valid  : averaged word available
//   out_ready  : downstream accepts
//   out_data   : averaged signed sample
//   out_ch     : channel of out_data
//   out_last   : high with the last channel's word
//   ovf        : sticky, a whole result block was dropped
//   sync_err   : sticky, frame framing was violated
module ad7606_avg
  import ad7606_pkg::*;
#(
  parameter int AVG_LOG2 = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 in_sof,
  input  logic signed [DW-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_data,
  output logic [CH_W-1:0]      out_ch,
  output logic                 out_last,
  output logic                 ovf,
  output logic                 sync_err
);

  // With AVG_LOG2 = 0 every frame is final; keep a 1-bit counter parked at 0.
  localparam int                CNT_W     = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0]  LAST_CONV = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(CH_NUM - 1);

  logic                 synced;
  logic [CH_W-1:0]      ch_cnt;
  logic [CNT_W-1:0]     conv_cnt;
  logic                 drop_flag;
  logic                 buf_full;
  out_state_t           state;
  logic [CH_W-1:0]      rd_idx;
  logic signed [DW-1:0] avg_buf [CH_NUM];
  logic signed [DW-1:0] avg_w   [CH_NUM];

  logic                 word_ok;
  logic [CH_W-1:0]      word_ch;
  logic                 restart;
  logic                 abort;
  logic                 clr_all;
  logic [CNT_W-1:0]     conv_eff;
  logic                 final_frame;
  logic                 last_hs;
  logic                 drop_now;
  logic                 blk_drop;
  logic                 set_full;
  logic [CH_W-1:0]      rd_nxt;

  // Framing decode. A restart (short frame) lets the sof word begin a new
  // block; an abort (long frame) drops the word and waits for the next sof.
  // The drop decision is taken on the final frame's channel-0 word and then
  // remembered for the rest of that frame.
  always_comb begin
    word_ok = 1'b0;
    word_ch = ch_cnt;
    restart = 1'b0;
    abort   = 1'b0;
    if (in_valid) begin
      if (in_sof) begin
        word_ok = 1'b1;
        word_ch = '0;
        restart = synced && (ch_cnt != LAST_CH);
      end else if (synced) begin
        if (ch_cnt == LAST_CH) begin
          abort = 1'b1;
        end else begin
          word_ok = 1'b1;
          word_ch = ch_cnt + 1'b1;
        end
      end
    end
    clr_all     = restart || abort;
    conv_eff    = clr_all ? '0 : conv_cnt;
    final_frame = (conv_eff == LAST_CONV);
    last_hs     = out_valid && out_ready && out_last;
    drop_now    = buf_full && !last_hs;
    blk_drop    = (word_ch == '0) ? drop_now : drop_flag;
    set_full    = word_ok && final_frame && !blk_drop && (word_ch == LAST_CH);
    rd_nxt      = rd_idx + 1'b1;
  end

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    ad7606_avg_acc #(
      .AVG_LOG2(AVG_LOG2)
    ) u_acc (
      .clk (clk),
      .rst (rst),
      .en  (word_ok && (word_ch == CH_W'(i))),
      .clr (clr_all),
      .fin (final_frame),
      .data(in_data),
      .avg (avg_w[i])
    );
  end

  // Frame/block bookkeeping, result buffer and sticky status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      synced    <= 1'b0;
      ch_cnt    <= '0;
      conv_cnt  <= '0;
      drop_flag <= 1'b0;
      buf_full  <= 1'b0;
      ovf       <= 1'b0;
      sync_err  <= 1'b0;
      for (int i = 0; i < CH_NUM; i++) begin
        avg_buf[i] <= '0;
      end
    end else begin
      if (clr_all) begin
        conv_cnt <= '0;
        sync_err <= 1'b1;
      end
      if (abort) begin
        synced <= 1'b0;
      end
      if (word_ok) begin
        synced <= 1'b1;
        ch_cnt <= word_ch;
        if (word_ch == LAST_CH) begin
          conv_cnt <= final_frame ? '0 : conv_eff + 1'b1;
        end
        if (final_frame) begin
          if (word_ch == '0) begin
            drop_flag <= drop_now;
            if (drop_now) begin
              ovf <= 1'b1;
            end
          end
          if (!blk_drop) begin
            avg_buf[word_ch] <= avg_w[word_ch];
          end
        end
      end
      if (set_full) begin
        buf_full <= 1'b1;
      end else if (last_hs) begin
        buf_full <= 1'b0;
      end
    end
  end

  // Output stream. SEND is entered on the same edge that fills the buffer so
  // out_valid appears the cycle after the block's last word; channel 0 of the
  // buffer was written earlier in that frame and is already stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rd_idx    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (set_full) begin
            state     <= SEND;
            rd_idx    <= '0;
            out_valid <= 1'b1;
            out_data  <= avg_buf[0];
            out_ch    <= '0;
            out_last  <= (CH_NUM == 1);
          end
        end
        SEND: begin
          if (out_ready) begin
            if (rd_idx == LAST_CH) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end else begin
              rd_idx   <= rd_nxt;
              out_data <= avg_buf[rd_nxt];
              out_ch   <= rd_nxt;
              out_last <= (rd_nxt == LAST_CH);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ad7606_avg.sv
// tb_ad7606_avg
// Directed + randomized bench for ad7606_avg with AVG_LOG2 = 2. Expected
// averages come from per-channel frame sums and floor division; a monitor
// compares every accepted output word against the expected queue.
module tb_ad7606_avg;

  localparam int AVG_LOG2 = 2;
  localparam int AVG_N    = 1 << AVG_LOG2;
  localparam int NCH      = 8;

  logic               clk       = 1'b0;
  logic               rst       = 1'b1;
  logic               in_valid  = 1'b0;
  logic               in_sof    = 1'b0;
  logic signed [15:0] in_data   = '0;
  logic               out_ready = 1'b0;
  logic               out_valid;
  logic signed [15:0] out_data;
  logic [2:0]         out_ch;
  logic               out_last;
  logic               ovf;
  logic               sync_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int data;
    int ch;
  } exp_t;

  exp_t exp_q[$];
  int   model_sum[NCH];
  int   model_n;
  bit   expect_push;

  always #10 clk = ~clk;

  ad7606_avg #(
    .AVG_LOG2(AVG_LOG2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_sof   (in_sof),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ch   (out_ch),
    .out_last (out_last),
    .ovf      (ovf),
    .sync_err (sync_err)
  );

  task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                             input int expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Floor division by the block size, rounding toward minus infinity.
  function automatic int floor_div(input int s);
    int q;
    q = s / AVG_N;
    if ((s % AVG_N) != 0 && s < 0) q = q - 1;
    return q;
  endfunction

  function automatic int rand_sample();
    return int'($urandom_range(65535)) - 32768;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < NCH; k++) model_sum[k] = 0;
    model_n = 0;
  endtask

  // One input word, held for exactly one clock.
  task automatic applyStimulus(input logic sof, input int data);
    in_valid = 1'b1;
    in_sof   = sof;
    in_data  = 16'(data);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic send_frame(input int vals[NCH]);
    exp_t e;
    for (int k = 0; k < NCH; k++) applyStimulus(k == 0, vals[k]);
    for (int k = 0; k < NCH; k++) model_sum[k] += vals[k];
    model_n++;
    if (model_n == AVG_N) begin
      if (expect_push) begin
        for (int k = 0; k < NCH; k++) begin
          e.data = floor_div(model_sum[k]);
          e.ch   = k;
          exp_q.push_back(e);
        end
      end
      model_clear();
    end
  endtask

  task automatic send_random_block();
    int vals[NCH];
    for (int f = 0; f < AVG_N; f++) begin
      for (int k = 0; k < NCH; k++) vals[k] = rand_sample();
      send_frame(vals);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput(tag, out_valid, 1);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    checkOutput({tag, "_drained"}, exp_q.size(), 0);
    checkOutput({tag, "_idle"}, out_valid, 0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    exp_q.delete();
  endtask

  // Monitor: every accepted word must match the next expected word, and a
  // stalled word must not change until it is accepted.
  logic               stall_prev = 1'b0;
  logic signed [15:0] data_prev  = '0;
  logic [2:0]         ch_prev    = '0;
  logic               last_prev  = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (out_valid && stall_prev) begin
      checkOutput("hold_data", out_data, int'(data_prev));
      checkOutput("hold_ch", out_ch, int'(ch_prev));
      checkOutput("hold_last", out_last, int'(last_prev));
    end
    if (out_valid && out_ready) begin
      checkOutput("word_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("out_data", out_data, e.data);
        checkOutput("out_ch", out_ch, e.ch);
        checkOutput("out_last", out_last, (e.ch == NCH - 1) ? 1 : 0);
      end
    end
    stall_prev = out_valid && !out_ready;
    data_prev  = out_data;
    ch_prev    = out_ch;
    last_prev  = out_last;
  end

  initial begin
    int vals[NCH];
    model_clear();
    expect_push = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_out_ch", out_ch, 0);
    checkOutput("rst_out_last", out_last, 0);
    checkOutput("rst_ovf", ovf, 0);
    checkOutput("rst_sync_err", sync_err, 0);

    // Basic average: ch k = 1000 + k in every frame
    $display("[TB] basic average");
    out_ready = 1'b1;
    for (int f = 0; f < AVG_N; f++) begin
      for (int k = 0; k < NCH; k++) vals[k] = 1000 + k;
      if (f == AVG_N - 1) checkOutput("basic_pre_valid", out_valid, 0);
      send_frame(vals);
    end
    checkOutput("basic_valid_latency", out_valid, 1);
    checkOutput("basic_first_data", out_data, 1000);
    wait_drain("basic");

    // Floor rounding on negative and positive sums
    $display("[TB] floor rounding");
    for (int f = 0; f < AVG_N; f++) begin
      for (int k = 0; k < NCH; k++) vals[k] = rand_sample();
      vals[0] = (f == 0) ? -1 : -2;
      vals[1] = (f == 0) ? 1 : 2;
      send_frame(vals);
    end
    checkOutput("floor_ch0", out_data, -2);
    wait_drain("floor");

    // Backpressure: word 0 must hold for 20 cycles
    $display("[TB] backpressure");
    out_ready = 1'b0;
    send_random_block();
    wait_valid("bp_valid");
    repeat (20) @(posedge clk);
    #1;
    checkOutput("bp_hold_valid", out_valid, 1);
    checkOutput("bp_hold_ch", out_ch, 0);
    checkOutput("bp_hold_data", out_data, exp_q[0].data);
    checkOutput("bp_queue", exp_q.size(), NCH);
    out_ready = 1'b1;
    wait_drain("bp");
    checkOutput("bp_ovf", ovf, 0);

    // Overrun: second block arrives while the first is still stalled
    $display("[TB] overrun");
    out_ready = 1'b0;
    send_random_block();
    wait_valid("ovr_valid");
    expect_push = 1'b0;
    send_random_block();
    expect_push = 1'b1;
    checkOutput("ovr_ovf", ovf, 1);
    out_ready = 1'b1;
    wait_drain("ovr_first");
    send_random_block();
    wait_drain("ovr_next");
    checkOutput("ovr_ovf_sticky", ovf, 1);

    // Short frame: sof after 5 words
    $display("[TB] short frame");
    doReset();
    checkOutput("short_rst_ovf", ovf, 0);
    applyStimulus(1'b1, rand_sample());
    for (int k = 1; k < 5; k++) applyStimulus(1'b0, rand_sample());
    checkOutput("short_pre_err", sync_err, 0);
    for (int f = 0; f < AVG_N; f++) begin
      for (int k = 0; k < NCH; k++) vals[k] = 500;
      send_frame(vals);
    end
    checkOutput("short_sync_err", sync_err, 1);
    wait_drain("short");

    // Long frame: a 9th non-sof word, then stray words until the next sof
    $display("[TB] long frame");
    doReset();
    for (int k = 0; k < NCH; k++) vals[k] = rand_sample();
    send_frame(vals);
    checkOutput("long_pre_err", sync_err, 0);
    applyStimulus(1'b0, rand_sample());
    checkOutput("long_sync_err", sync_err, 1);
    model_clear();
    repeat (3) applyStimulus(1'b0, rand_sample());
    send_random_block();
    wait_drain("long");

    // Reset in the middle of a drain
    $display("[TB] reset mid-drain");
    out_ready = 1'b0;
    send_random_block();
    wait_valid("mid_valid");
    checkOutput("mid_sync_err_pre", sync_err, 1);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("mid_three_words", exp_q.size(), NCH - 3);
    doReset();
    checkOutput("mid_rst_valid", out_valid, 0);
    checkOutput("mid_rst_ovf", ovf, 0);
    checkOutput("mid_rst_sync_err", sync_err, 0);
    repeat (5) applyStimulus(1'b0, rand_sample());
    checkOutput("mid_unsynced_idle", out_valid, 0);
    out_ready = 1'b1;
    send_random_block();
    checkOutput("mid_block_valid", out_valid, 1);
    wait_drain("mid_block");
    checkOutput("mid_final_sync_err", sync_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
